// File: rtl/dispscan_pkg.sv
// Shared types and constants for the display scan controller.
package dispscan_pkg;

    localparam int unsigned NIB_W     = 4;
    localparam int unsigned DEF_DIV   = 50000;
    localparam int unsigned DEF_BLANK = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } state_e;

endpackage

// File: rtl/dispscan_if.sv
// Load/ack handshake and scan outputs of the display scan controller.
interface dispscan_if #(
    parameter int unsigned DIGITS = 4
);
    import dispscan_pkg::*;

    logic                      EN;
    logic [NIB_W*DIGITS-1:0]   VAL;
    logic                      LOAD;
    logic                      ACK;
    logic [NIB_W-1:0]          DISP;
    logic [DIGITS-1:0]         AN;

    modport master (output EN, VAL, LOAD, input ACK, DISP, AN);
    modport slave  (input EN, VAL, LOAD, output ACK, DISP, AN);

endinterface

// File: rtl/dispscan_tick.sv
// Loadable down-counter; tc_o is high while the count is zero.
module dispscan_tick #(
    parameter int unsigned W = 3
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Reload on request, otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/dispscan_ctrl.sv
// Time-multiplexed digit scan controller with frame-aligned value commit.
// Optional leading-zero blanking: define DISPSCAN_LZB_EN.
module dispscan_ctrl
    import dispscan_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned DIV    = DEF_DIV,
    parameter int unsigned BLANK  = DEF_BLANK
) (
    input  logic      CLK,
    input  logic      RST_N,
    dispscan_if.slave bus
);

    localparam int unsigned IDX_W   = $clog2(DIGITS);
    localparam int unsigned VAL_W   = NIB_W * DIGITS;
    // Sized for DIV; widened only if BLANK ever exceeds DIV.
    localparam int unsigned CNT_MAX = (DIV > BLANK) ? DIV : BLANK;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] SHOW_LD  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'((BLANK == 0) ? 0 : BLANK - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [VAL_W-1:0]   active_q, active_d;
    logic [VAL_W-1:0]   pend_val_q, pend_val_d;
    logic               pend_q, pend_d;
    logic               ack_q, ack_d;
    logic [DIGITS-1:0]  an_q, an_d;
    logic [NIB_W-1:0]   disp_q, disp_d;

    logic               tick_load;
    logic [CNT_W-1:0]   tick_val;
    logic               tick_tc;
    logic               frame_end;
    logic               lzb_hide;

    dispscan_tick #(.W(CNT_W)) u_tick (
        .clk_i      (CLK),
        .rst_ni     (RST_N),
        .load_i     (tick_load),
        .load_val_i (tick_val),
        .tc_o       (tick_tc)
    );

    // Scan sequencing: state, digit index and prescaler reloads.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tick_load = 1'b0;
        tick_val  = '0;
        frame_end = 1'b0;
        if (!bus.EN) begin
            state_d   = ST_IDLE;
            idx_d     = '0;
            tick_load = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_SHOW;
                    idx_d     = '0;
                    tick_load = 1'b1;
                    tick_val  = SHOW_LD;
                end
                ST_SHOW: begin
                    if (tick_tc) begin
                        tick_load = 1'b1;
                        if (BLANK != 0) begin
                            state_d  = ST_BLANK;
                            tick_val = BLANK_LD;
                        end else begin
                            frame_end = (idx_q == LAST_IDX);
                            idx_d     = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                            tick_val  = SHOW_LD;
                        end
                    end
                end
                ST_BLANK: begin
                    if (tick_tc) begin
                        tick_load = 1'b1;
                        state_d   = ST_SHOW;
                        tick_val  = SHOW_LD;
                        frame_end = (idx_q == LAST_IDX);
                        idx_d     = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    idx_d     = '0;
                    tick_load = 1'b1;
                end
            endcase
        end
    end

    // Value handshake: commit in IDLE or at a frame boundary, else hold pending.
    always_comb begin
        active_d   = active_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;
        ack_d      = 1'b0;
        if (((state_q == ST_IDLE) || frame_end) && bus.LOAD) begin
            active_d = bus.VAL;
            pend_d   = 1'b0;
            ack_d    = 1'b1;
        end else if (((state_q == ST_IDLE) || frame_end) && pend_q) begin
            active_d = pend_val_q;
            pend_d   = 1'b0;
            ack_d    = 1'b1;
        end else if (bus.LOAD) begin
            pend_val_d = bus.VAL;
            pend_d     = 1'b1;
        end
    end

    // Registered outputs are derived from next-state so they align with it.
    always_comb begin
`ifdef DISPSCAN_LZB_EN
        lzb_hide = (idx_d != '0) && ((active_d >> (NIB_W * idx_d)) == '0);
`else
        lzb_hide = 1'b0;
`endif
        an_d   = '0;
        disp_d = '0;
        case (state_d)
            ST_SHOW: begin
                an_d   = lzb_hide ? '0 : (DIGITS'(1) << idx_d);
                disp_d = active_d[NIB_W*idx_d +: NIB_W];
            end
            ST_BLANK: disp_d = disp_q;
            default:  disp_d = '0;
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            active_q   <= '0;
            pend_val_q <= '0;
            pend_q     <= 1'b0;
            ack_q      <= 1'b0;
            an_q       <= '0;
            disp_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            active_q   <= active_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            ack_q      <= ack_d;
            an_q       <= an_d;
            disp_q     <= disp_d;
        end
    end

    assign bus.ACK  = ack_q;
    assign bus.DISP = disp_q;
    assign bus.AN   = an_q;

endmodule
